// File: rtl/gpr_regfile.sv
// ---------------------------------------------------------------------------
// gpr_regfile -- general-purpose register file with issue scoreboard
//
// Holds 2^ADDR_WIDTH registers of DATA_WIDTH bits (register 0 reads as zero)
// with two combinational read ports and one write-back port. A busy bit per
// register tracks destinations that have been issued but not yet written
// back. A registered count of set busy bits is also provided.
//
// Configuration macro:
//   GPR_BYPASS_EN  When defined, a write-back in the current cycle is
//                  forwarded combinationally to a read port addressing the
//                  same nonzero index (data = wb_data, busy forced to 0).
//                  When undefined, read ports show stored state only.
//
// Ports:
//   clk          in   clock, all state updates on rising edge
//   rst          in   asynchronous active-high reset
//   rs1_addr     in   read port 1 index
//   rs2_addr     in   read port 2 index
//   src1         out  read port 1 data
//   src2         out  read port 2 data
//   rs1_busy     out  read port 1 index has an outstanding write
//   rs2_busy     out  read port 2 index has an outstanding write
//   issue_en     in   mark issue_addr as pending writer
//   issue_addr   in   destination index being issued
//   wb_en        in   write-back strobe
//   wb_addr      in   write-back destination index
//   wb_data      in   write-back data
//   pending_cnt  out  number of registers currently busy (registered)
// ---------------------------------------------------------------------------

`ifndef ISA_WIDTH
`define ISA_WIDTH 32
`endif

module gpr_regfile #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = `ISA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] rs1_addr,
    input  logic [ADDR_WIDTH-1:0] rs2_addr,
    output logic [DATA_WIDTH-1:0] src1,
    output logic [DATA_WIDTH-1:0] src2,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    input  logic                  issue_en,
    input  logic [ADDR_WIDTH-1:0] issue_addr,
    input  logic                  wb_en,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic [ADDR_WIDTH:0]   pending_cnt
);

    localparam int NUM_REGS = 1 << ADDR_WIDTH;
    localparam int CNT_W    = ADDR_WIDTH + 1;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]   busy;
    logic [NUM_REGS-1:0]   busy_next;
    logic [CNT_W-1:0]      cnt_q;

    // Index 0 is hard-wired: neither writes nor issues to it have any effect.
    logic wb_hit;
    logic issue_hit;

    assign wb_hit    = wb_en    && (wb_addr    != '0);
    assign issue_hit = issue_en && (issue_addr != '0);

    // Population count of a busy vector. Bounded by NUM_REGS-1 because
    // busy[0] is never set, so CNT_W bits are always sufficient.
    function automatic logic [CNT_W-1:0] popcount(input logic [NUM_REGS-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    // -----------------------------------------------------------------------
    // Scoreboard next state: write-back clears, issue sets. Issue is applied
    // last so a same-edge issue and write-back to one index leaves it busy.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinationally assigned variable gets a default first,
        // otherwise untaken branches infer latches.
        busy_next = busy;
        if (wb_hit) begin
            busy_next[wb_addr] = 1'b0;
        end
        if (issue_hit) begin
            busy_next[issue_addr] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // -----------------------------------------------------------------------
    // Sequential update. The count is taken from busy_next so that it stays
    // in step with the busy vector it describes.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: register storage is cleared on reset here because software
            // relies on every GPR reading zero after reset; a plain RAM array
            // would normally be left unreset so it can map to memory macros.
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            busy  <= '0;
            cnt_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            if (wb_hit) begin
                regs[wb_addr] <= wb_data;
            end
            busy  <= busy_next;
            cnt_q <= popcount(busy_next);
        end
    end

    assign pending_cnt = cnt_q;

    // -----------------------------------------------------------------------
    // Read ports. Index 0 is forced to zero even though regs[0] is never
    // written, which keeps the zero register independent of storage.
    // -----------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] stored1;
    logic [DATA_WIDTH-1:0] stored2;

    assign stored1 = (rs1_addr == '0) ? '0 : regs[rs1_addr];
    assign stored2 = (rs2_addr == '0) ? '0 : regs[rs2_addr];

`ifdef GPR_BYPASS_EN
    // Forwarding is suppressed during reset so outputs read as zero while
    // rst is high, even if a write-back strobe is present.
    logic byp1;
    logic byp2;

    assign byp1 = !rst && wb_hit && (wb_addr == rs1_addr);
    assign byp2 = !rst && wb_hit && (wb_addr == rs2_addr);

    assign src1     = byp1 ? wb_data : stored1;
    assign src2     = byp2 ? wb_data : stored2;
    assign rs1_busy = byp1 ? 1'b0    : busy[rs1_addr];
    assign rs2_busy = byp2 ? 1'b0    : busy[rs2_addr];
`else
    assign src1     = stored1;
    assign src2     = stored2;
    assign rs1_busy = busy[rs1_addr];
    assign rs2_busy = busy[rs2_addr];
`endif

endmodule

// File: tb/tb_gpr_regfile.sv
// ---------------------------------------------------------------------------
// tb_gpr_regfile -- directed, table-driven bench for gpr_regfile.
// Each table record is applied across one rising edge; strobes are then
// dropped and the read ports are compared against hand-computed values.
// Hand-written sequences cover same-cycle bypass behaviour and async reset.
// ---------------------------------------------------------------------------

module tb_gpr_regfile;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] rs1_addr, rs2_addr;
    logic [DW-1:0] src1, src2;
    logic          rs1_busy, rs2_busy;
    logic          issue_en;
    logic [AW-1:0] issue_addr;
    logic          wb_en;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic [AW:0]   pending_cnt;

    gpr_regfile #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .src1        (src1),
        .src2        (src2),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .issue_en    (issue_en),
        .issue_addr  (issue_addr),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .pending_cnt (pending_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic          issue_en;
        logic [AW-1:0] issue_addr;
        logic          wb_en;
        logic [AW-1:0] wb_addr;
        logic [DW-1:0] wb_data;
        logic [AW-1:0] rs1;
        logic [AW-1:0] rs2;
        logic [DW-1:0] e_src1;
        logic [DW-1:0] e_src2;
        logic          e_b1;
        logic          e_b2;
        logic [AW:0]   e_cnt;
    } vec_t;

    vec_t vecs[14];

    task automatic idle_inputs();
        issue_en   = 1'b0;
        issue_addr = '0;
        wb_en      = 1'b0;
        wb_addr    = '0;
        wb_data    = '0;
    endtask

    initial begin
        //          iss  ia  wb  wa  wdata          rs1 rs2 e_src1         e_src2         b1 b2 cnt
        vecs[0]  = '{0,  0,  0,  0,  32'h0,         0,  31, 32'h0,         32'h0,         0, 0, 0};
        vecs[1]  = '{0,  0,  1,  5,  32'hDEADBEEF,  5,  0,  32'hDEADBEEF,  32'h0,         0, 0, 0};
        vecs[2]  = '{0,  0,  1,  0,  32'h1234,      5,  0,  32'hDEADBEEF,  32'h0,         0, 0, 0};
        vecs[3]  = '{1,  3,  0,  0,  32'h0,         3,  5,  32'h0,         32'hDEADBEEF,  1, 0, 1};
        vecs[4]  = '{0,  0,  1,  3,  32'h7,         3,  3,  32'h7,         32'h7,         0, 0, 0};
        vecs[5]  = '{1,  8,  0,  0,  32'h0,         8,  8,  32'h0,         32'h0,         1, 1, 1};
        vecs[6]  = '{1,  8,  1,  8,  32'h55,        8,  8,  32'h55,        32'h55,        1, 1, 1};
        vecs[7]  = '{1,  10, 1,  10, 32'hAA,        10, 8,  32'hAA,        32'h55,        1, 1, 2};
        vecs[8]  = '{1,  0,  1,  0,  32'hFF,        0,  10, 32'h0,         32'hAA,        0, 1, 2};
        vecs[9]  = '{1,  10, 0,  0,  32'h0,         10, 10, 32'hAA,        32'hAA,        1, 1, 2};
        vecs[10] = '{0,  0,  1,  12, 32'h12,        12, 10, 32'h12,        32'hAA,        0, 1, 2};
        vecs[11] = '{1,  31, 1,  8,  32'h66,        8,  31, 32'h66,        32'h0,         0, 1, 2};
        vecs[12] = '{0,  0,  1,  10, 32'h77,        10, 31, 32'h77,        32'h0,         0, 1, 1};
        vecs[13] = '{0,  0,  1,  31, 32'hFFFFFFFF,  31, 0,  32'hFFFFFFFF,  32'h0,         0, 0, 0};

        idle_inputs();
        rs1_addr = '0;
        rs2_addr = '0;
        rst      = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Post-reset sweep of every index on both ports.
        for (int a = 0; a < (1 << AW); a++) begin
            rs1_addr = AW'(a);
            rs2_addr = AW'((1 << AW) - 1 - a);
            #1;
            check($sformatf("reset_src1[%0d]", a), src1, 32'h0);
            check($sformatf("reset_src2[%0d]", a), src2, 32'h0);
            check($sformatf("reset_busy[%0d]", a), {30'h0, rs1_busy, rs2_busy}, 32'h0);
        end
        check("reset_cnt", 32'(pending_cnt), 32'h0);

        // Table-driven vectors.
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            issue_en   = vecs[i].issue_en;
            issue_addr = vecs[i].issue_addr;
            wb_en      = vecs[i].wb_en;
            wb_addr    = vecs[i].wb_addr;
            wb_data    = vecs[i].wb_data;
            rs1_addr   = vecs[i].rs1;
            rs2_addr   = vecs[i].rs2;
            @(posedge clk);
            #1;
            idle_inputs();
            #1;
            check($sformatf("v%0d_src1", i), src1, vecs[i].e_src1);
            check($sformatf("v%0d_src2", i), src2, vecs[i].e_src2);
            check($sformatf("v%0d_b1", i), 32'(rs1_busy), 32'(vecs[i].e_b1));
            check($sformatf("v%0d_b2", i), 32'(rs2_busy), 32'(vecs[i].e_b2));
            check($sformatf("v%0d_cnt", i), 32'(pending_cnt), 32'(vecs[i].e_cnt));
        end

        // Same-cycle write-back visibility: reg 9 busy with value 1.
        @(negedge clk);
        issue_en = 1'b1; issue_addr = 5'd9;
        wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h1;
        @(posedge clk);
        #1;
        idle_inputs();
        @(negedge clk);
        rs1_addr = 5'd9;
        rs2_addr = 5'd9;
        #1;
        check("byp_pre_src1", src1, 32'h1);
        check("byp_pre_b1", 32'(rs1_busy), 32'h1);
        check("byp_pre_cnt", 32'(pending_cnt), 32'h1);
        wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'hA5;
        #1;
`ifdef GPR_BYPASS_EN
        check("byp_same_src1", src1, 32'hA5);
        check("byp_same_b1", 32'(rs1_busy), 32'h0);
        check("byp_same_src2", src2, 32'hA5);
`else
        check("byp_same_src1", src1, 32'h1);
        check("byp_same_b1", 32'(rs1_busy), 32'h1);
        check("byp_same_src2", src2, 32'h1);
`endif
        @(posedge clk);
        #1;
        idle_inputs();
        #1;
        check("byp_post_src1", src1, 32'hA5);
        check("byp_post_b1", 32'(rs1_busy), 32'h0);
        check("byp_post_cnt", 32'(pending_cnt), 32'h0);

        // Issue 1, 2, 4 then assert reset asynchronously mid-cycle.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            issue_en   = 1'b1;
            issue_addr = (k == 0) ? 5'd1 : (k == 1) ? 5'd2 : 5'd4;
        end
        @(posedge clk);
        #1;
        idle_inputs();
        rs1_addr = 5'd4;
        rs2_addr = 5'd1;
        #1;
        check("rst_pre_cnt", 32'(pending_cnt), 32'h3);
        check("rst_pre_busy", {30'h0, rs1_busy, rs2_busy}, 32'h3);
        rs1_addr = 5'd5;
        #1;
        check("rst_pre_src1", src1, 32'hDEADBEEF);
        rst = 1'b1;
        rs2_addr = 5'd4;
        #1;
        check("rst_async_cnt", 32'(pending_cnt), 32'h0);
        check("rst_async_src1", src1, 32'h0);
        check("rst_async_b2", 32'(rs2_busy), 32'h0);
        // A write-back strobe across an edge while reset is held is discarded.
        wb_en = 1'b1; wb_addr = 5'd6; wb_data = 32'hCAFE;
        issue_en = 1'b1; issue_addr = 5'd6;
        rs1_addr = 5'd6;
        #1;
        check("rst_hold_src1", src1, 32'h0);
        check("rst_hold_b1", 32'(rs1_busy), 32'h0);
        @(posedge clk);
        #1;
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_after_src1", src1, 32'h0);
        check("rst_after_b1", 32'(rs1_busy), 32'h0);
        check("rst_after_cnt", 32'(pending_cnt), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
